// File: rtl/mux6_arb_if.sv
// Handshake/bus bundle between the mux6_arb arbiter and its channel selector
// and consumer. The master modport is the arbiter side.
interface mux6_arb_if #(
   parameter int DATA_W = 8
);
   logic [5:0]        req;
   logic [2:0]        sel;
   logic [DATA_W-1:0] din;
   logic [5:0]        grant;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic [2:0]        dout_ch;

   modport master (
      input  req, din, dout_ready,
      output sel, grant, dout, dout_valid, dout_ch
   );

   modport slave (
      output req, din, dout_ready,
      input  sel, grant, dout, dout_valid, dout_ch
   );
endinterface

// File: rtl/mux6_arb.sv
// Six-channel arbiter driving an external 6:1 selector and capturing one word per transfer.
// Define MUX6_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mux6_arb #(
   parameter int DATA_W = 8,
   parameter int NCH    = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   mux6_arb_if.master bus
);

   if (NCH != 6) begin : g_nch_check
      $error("mux6_arb supports NCH == 6 only");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [2:0]        r_sel;
   logic [2:0]        r_ptr;
   logic [2:0]        r_dout_ch;
   logic [5:0]        r_grant;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_valid;

   logic [2:0]        w_winner;
   logic [2:0]        w_ptr_next;

`ifdef MUX6_ARB_FIXED_PRIO_EN
   function automatic logic [2:0] pick_fixed(input logic [5:0] req);
      logic [2:0] win;
      win = 3'd0;
      for (int k = 5; k >= 0; k--) begin
         if (req[k]) win = 3'(k);
      end
      return win;
   endfunction
`else
   // First set request at or after ptr, wrapping 5 -> 0.
   function automatic logic [2:0] pick_rr(input logic [5:0] req, input logic [2:0] ptr);
      logic [2:0] win;
      logic       found;
      int         base;
      int         idx;
      win   = 3'd0;
      found = 1'b0;
      base  = (ptr > 3'd5) ? 0 : int'(ptr);
      for (int k = 0; k < 6; k++) begin
         idx = base + k;
         if (idx >= 6) idx = idx - 6;
         if (!found && req[idx]) begin
            win   = 3'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_winner = 3'd0;
`ifdef MUX6_ARB_FIXED_PRIO_EN
      w_winner = pick_fixed(bus.req);
`else
      w_winner = pick_rr(bus.req, r_ptr);
`endif
   end

   assign w_ptr_next = (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_sel        <= 3'd0;
         r_ptr        <= 3'd0;
         r_dout_ch    <= 3'd0;
         r_grant      <= 6'd0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_grant <= 6'd0;
         case (r_state)
            IDLE: begin
               if (|bus.req) begin
                  r_sel   <= w_winner;
                  r_state <= CAPT;
               end
            end
            CAPT: begin
               r_dout       <= bus.din;
               r_dout_ch    <= r_sel;
               r_grant      <= 6'd1 << r_sel;
               r_dout_valid <= 1'b1;
               r_state      <= HOLD;
            end
            HOLD: begin
               if (bus.dout_ready) begin
                  r_dout_valid <= 1'b0;
                  r_ptr        <= w_ptr_next;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sel        = r_sel;
   assign bus.grant      = r_grant;
   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.dout_ch    = r_dout_ch;

endmodule

// File: tb/tb_mux6_arb.sv
// Self-checking bench for mux6_arb: directed scenarios plus randomized traffic
// against a transfer-level reference model.
module tb_mux6_arb;

   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mux6_arb_if #(.DATA_W(DATA_W)) bus ();

   mux6_arb #(.DATA_W(DATA_W), .NCH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [DATA_W-1:0] words [6];

   // Downstream 6:1 selector model.
   assign bus.din = (bus.sel < 3'd6) ? words[bus.sel] : '0;

   int errors = 0;
   int checks = 0;

   // Reference model state: a transfer is pending capture, or a word is held.
   bit          m_pend;
   bit          m_valid;
   int          m_win;
   int          m_ptr;
   int          m_sel;
   logic [7:0]  m_dout;
   int          m_ch;
   logic [5:0]  m_grant;

   // Observation tallies for directed scenarios.
   int          n_grants;
   int          n_valid;
   logic [5:0]  first_grant;
   logic [5:0]  grant_seen;
   logic [7:0]  cap_dout;
   logic [2:0]  cap_ch;
   logic [7:0]  q_dout [$];
   logic [2:0]  q_ch [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_pick(input logic [5:0] r, input int ptr);
`ifdef MUX6_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 6; i++) if (r[i]) return i;
`else
      for (int k = 0; k < 6; k++) if (r[(ptr + k) % 6]) return (ptr + k) % 6;
`endif
      return 0;
   endfunction

   task automatic model_reset();
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_win   = 0;
      m_ptr   = 0;
      m_sel   = 0;
      m_dout  = 8'h00;
      m_ch    = 0;
      m_grant = 6'd0;
   endtask

   task automatic model_edge();
      m_grant = 6'd0;
      if (m_pend) begin
         m_dout  = words[m_win];
         m_ch    = m_win;
         m_valid = 1'b1;
         m_grant = 6'b1 << m_win;
         m_pend  = 1'b0;
      end else if (m_valid) begin
         if (bus.dout_ready) begin
            m_valid = 1'b0;
            m_ptr   = (m_win + 1) % 6;
         end
      end else if (bus.req != 6'd0) begin
         m_win  = ref_pick(bus.req, m_ptr);
         m_sel  = m_win;
         m_pend = 1'b1;
      end
   endtask

   task automatic compare_outputs(input string ctx);
      check({ctx, "_sel"},    bus.sel,        m_sel);
      check({ctx, "_grant"},  bus.grant,      m_grant);
      check({ctx, "_valid"},  bus.dout_valid, m_valid);
      check({ctx, "_dout"},   bus.dout,       m_dout);
      check({ctx, "_ch"},     bus.dout_ch,    m_ch);
      check({ctx, "_sel_range"}, (bus.sel < 3'd6), 1);
      check({ctx, "_grant_onehot0"}, $onehot0(bus.grant), 1);
   endtask

   task automatic clear_tally();
      n_grants    = 0;
      n_valid     = 0;
      first_grant = 6'd0;
      grant_seen  = 6'd0;
      cap_dout    = 8'h00;
      cap_ch      = 3'd0;
      q_dout.delete();
      q_ch.delete();
   endtask

   // One clock: update the model with pre-edge inputs, then check outputs 1 time unit later.
   task automatic step(input string ctx = "cyc");
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      #1;
      compare_outputs(ctx);
      if (bus.grant != 6'd0) begin
         n_grants++;
         if (first_grant == 6'd0) first_grant = bus.grant;
         grant_seen = grant_seen | bus.grant;
         cap_dout   = bus.dout;
         cap_ch     = bus.dout_ch;
         q_dout.push_back(bus.dout);
         q_ch.push_back(bus.dout_ch);
      end
      if (bus.dout_valid) n_valid++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_outputs("rst_async");
      step("rst");
      step("rst");
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.grant == 6'd0 && n < budget) begin
         step(tag);
         n++;
      end
      check({tag, "_grant_timeout"}, (bus.grant != 6'd0), 1);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req        = 6'h3F;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) words[i] = 8'hE1 + 8'(i);
      model_reset();
      clear_tally();

      // Reset held for 3 cycles with every channel requesting.
      repeat (3) step("reset_hold");
      check("reset_no_grant", n_grants, 0);
      check("reset_no_valid", n_valid, 0);
      rst_n = 1'b1;

      // Single request on channel index 2.
      bus.req        = 6'b000100;
      bus.dout_ready = 1'b1;
      clear_tally();
      step("single");
      check("single_sel_after_arb", bus.sel, 2);
      bus.req = 6'd0;
      repeat (4) step("single");
      check("single_grant_count", n_grants, 1);
      check("single_grant_vec", grant_seen, 6'b000100);
      check("single_valid_cycles", n_valid, 1);
      check("single_dout", cap_dout, 8'hE3);
      check("single_dout_ch", cap_ch, 2);

      // Round-robin with all requests held.
      apply_reset();
      bus.req        = 6'h3F;
      bus.dout_ready = 1'b1;
      clear_tally();
      for (int n = 0; n < 40 && q_dout.size() < 7; n++) step("wrap");
      check("wrap_transfer_count", (q_dout.size() >= 7), 1);
      for (int i = 0; i < 7; i++) begin
         if (i < q_dout.size()) begin
`ifdef MUX6_ARB_FIXED_PRIO_EN
            check("wrap_dout", q_dout[i], 8'hE1);
            check("wrap_ch", q_ch[i], 0);
`else
            check("wrap_dout", q_dout[i], 8'hE1 + 8'(i % 6));
            check("wrap_ch", q_ch[i], i % 6);
`endif
         end
      end

      // Backpressure: word held stable while the consumer stalls.
      apply_reset();
      bus.req        = 6'b000001;
      bus.dout_ready = 1'b0;
      clear_tally();
      wait_grant("bp", 6);
      bus.req  = 6'd0;
      n_grants = 0;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_held", bus.dout_valid, 1);
         check("bp_dout_held", bus.dout, 8'hE1);
         check("bp_ch_held", bus.dout_ch, 0);
         step("bp");
      end
      bus.dout_ready = 1'b1;
      step("bp_accept");
      check("bp_valid_cleared", bus.dout_valid, 0);
      repeat (2) step("bp_idle");
      check("bp_no_dup_grant", n_grants, 0);

      // Request dropped right after arbitration still completes.
      apply_reset();
      bus.req        = 6'b100000;
      bus.dout_ready = 1'b1;
      clear_tally();
      step("drop");
      bus.req = 6'd0;
      repeat (3) step("drop");
      check("drop_grant_vec", grant_seen, 6'b100000);
      check("drop_dout", cap_dout, 8'hE6);
      check("drop_valid_cycles", n_valid, 1);

      // Reset pulsed while a word is held, then arbitration restarts from channel 0.
      bus.req        = 6'b100000;
      bus.dout_ready = 1'b0;
      clear_tally();
      step("midrst");
      bus.req = 6'd0;
      step("midrst");
      check("midrst_valid_before", bus.dout_valid, 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_valid_async", bus.dout_valid, 0);
      check("midrst_dout_async", bus.dout, 0);
      check("midrst_sel_async", bus.sel, 0);
      check("midrst_grant_async", bus.grant, 0);
      step("midrst_hold");
      rst_n          = 1'b1;
      bus.req        = 6'b100001;
      bus.dout_ready = 1'b1;
      clear_tally();
      wait_grant("midrst_restart", 6);
      check("midrst_first_grant", first_grant, 6'b000001);
      bus.req = 6'd0;
      repeat (3) step("midrst_tail");

      // Randomized traffic with occasional asynchronous resets.
      apply_reset();
      for (int n = 0; n < 500; n++) begin
         bus.req = 6'($urandom);
         if ($urandom_range(0, 2) == 0) bus.req = 6'd0;
         bus.dout_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 6; k++) words[k] = 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            compare_outputs("rand_rst");
            step("rand_rst");
            rst_n = 1'b1;
         end else begin
            step("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
